shape_scheduler: RTL and testbench
==================================

SHAPE_SCHEDULER -- requirements
Module: shape_scheduler

Interface
REQ-001 Parameter: CLEAR_EN, 1, when 1 a screen-clear pass runs before the circles; when 0 the clear pass is skipped.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start  in  1  level request to render the scene.
REQ-005 done  out  1  scene complete, held until start is low.
REQ-006 cfg_we  in  1  shape-table write strobe.
REQ-007 cfg_addr  in  2  table entry index 0..3.
REQ-008 cfg_data  in  27  {valid[26], cx[25:18], cy[17:11], r[10:3], colour[2:0]}.
REQ-009 fill_start  out  1; fill_done  in  1; fill_x  in  8; fill_y  in  7; fill_colour  in  3; fill_plot  in  1  clear-engine port.
REQ-010 circ_start  out  1; circ_done  in  1; circ_cx  out  8; circ_cy  out  7; circ_r  out  8; circ_colour  out  3  circle-engine control.
REQ-011 circ_x  in  8; circ_y  in  7; circ_colour_px  in  3; circ_plot  in  1  circle-engine pixel port.
REQ-012 vga_x  out  8; vga_y  out  7; vga_colour  out  3; vga_plot  out  1  shared VGA adapter port.
REQ-013 shapes_drawn  out  3  count of circles completed in the current scene.

Function
REQ-014 States SHALL be IDLE, CLEAR, CLR_DRAIN, SELECT, DRAW, DRW_DRAIN, FINISH.
REQ-015 IDLE: start=1 SHALL go to CLEAR if CLEAR_EN=1, else SELECT; shapes_drawn and the entry pointer SHALL be zeroed on that transition.
REQ-016 CLEAR: fill_start=1 held; fill_done=1 SHALL move to CLR_DRAIN with fill_start=0 on the next cycle.
REQ-017 CLR_DRAIN: wait for fill_done=0, then go to SELECT.
REQ-018 SELECT: if pointer<4 and entry[pointer] is valid, latch cx/cy/r/colour onto circ_* and go to DRAW; if the entry is invalid, increment the pointer and stay; if pointer=4, go to FINISH; one entry examined per cycle.
REQ-019 DRAW: circ_start=1 held and circ_* stable; circ_done=1 SHALL go to DRW_DRAIN, increment shapes_drawn, and increment the pointer.
REQ-020 DRW_DRAIN: wait for circ_done=0, then go to SELECT.
REQ-021 FINISH: done=1; when start=0, go to IDLE with done=0 on the next cycle.
REQ-022 VGA mux, combinational, zero latency: in CLEAR the vga_* outputs SHALL equal the fill_* inputs; in DRAW they SHALL equal circ_x/circ_y/circ_colour_px/circ_plot; in all other states vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-023 Engine plot inputs outside the owner's state SHALL never reach vga_plot.
REQ-024 cfg_we SHALL write the table only in IDLE; writes in any other state are ignored; a write and a start in the same IDLE cycle SHALL both take effect (the written entry is used).
REQ-025 start while not IDLE SHALL be ignored; start deasserted mid-scene SHALL NOT abort the scene.
REQ-026 Zero valid entries: the scene SHALL complete with shapes_drawn=0 after the clear pass, or without it if CLEAR_EN=0.
REQ-027 fill_start and circ_start SHALL never be high simultaneously.
REQ-028 shapes_drawn SHALL saturate at 4.

Reset
REQ-029 rst_n=0 sampled on a rising edge SHALL force IDLE, done=0, fill_start=0, circ_start=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, circ_*=0, shapes_drawn=0, and all table valid bits=0, including mid-operation.
REQ-030 After rst_n returns high, the first start SHALL be honoured on the same edge it is sampled.

Verification
REQ-031 Reset, then write entry0 = valid, cx=80, cy=60, r=40, colour=2 and hold start=1 -> CLEAR with fill_start=1; after fill_done, circ_start=1 with circ_cx=80, circ_cy=60, circ_r=40, circ_colour=2; after circ_done, done=1 and shapes_drawn=1.
REQ-032 Entries 0 and 2 valid, entries 1 and 3 invalid -> exactly two circ_start pulses in order 0 then 2, and shapes_drawn=2 at FINISH.
REQ-033 Drive fill_plot=1 during DRAW and circ_plot=1 during CLEAR -> vga_plot stays 0 in both cases; the owner's pixel passes through unchanged on the same cycle.
REQ-034 All entries invalid with CLEAR_EN=0 -> done=1 five cycles after start (SELECT x5 then FINISH), shapes_drawn=0, and no engine start asserted.
REQ-035 Assert rst_n=0 while in DRAW -> next cycle IDLE with circ_start=0 and vga_plot=0; a following start draws nothing because the table was cleared.
REQ-036 cfg_we with cx=10 during DRAW -> table unchanged; the next scene uses the old value.

Source files
------------

// File: rtl/shape_scheduler.sv
// Scene sequencer: optional screen-clear pass, then one circle per valid shape-table
// entry, with the VGA port muxed to whichever engine currently owns the screen.
module shape_scheduler #(
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        done,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [26:0] cfg_data,
    output logic        fill_start,
    input  logic        fill_done,
    input  logic [7:0]  fill_x,
    input  logic [6:0]  fill_y,
    input  logic [2:0]  fill_colour,
    input  logic        fill_plot,
    output logic        circ_start,
    input  logic        circ_done,
    output logic [7:0]  circ_cx,
    output logic [6:0]  circ_cy,
    output logic [7:0]  circ_r,
    output logic [2:0]  circ_colour,
    input  logic [7:0]  circ_x,
    input  logic [6:0]  circ_y,
    input  logic [2:0]  circ_colour_px,
    input  logic        circ_plot,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [2:0]  shapes_drawn
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_CLR_DRAIN = 3'd2,
        S_SELECT    = 3'd3,
        S_DRAW      = 3'd4,
        S_DRW_DRAIN = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  cx_q, cx_d;
    logic [6:0]  cy_q, cy_d;
    logic [7:0]  r_q, r_d;
    logic [2:0]  col_q, col_d;
    logic [26:0] entry_q [4];
    logic [26:0] entry_d [4];

    function automatic logic entry_valid(input logic [26:0] e);
        return e[26];
    endfunction

    // Next-state, pointer/count bookkeeping and shape-table writes
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        r_d     = r_q;
        col_d   = col_q;
        for (int i = 0; i < 4; i++) begin
            entry_d[i] = entry_q[i];
        end
        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    entry_d[cfg_addr] = cfg_data;
                end else begin
                    entry_d[cfg_addr] = entry_q[cfg_addr];
                end
                if (start) begin
                    ptr_d = 3'd0;
                    cnt_d = 3'd0;
                    if (CLEAR_EN) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_SELECT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (fill_done) state_d = S_CLR_DRAIN;
                else           state_d = S_CLEAR;
            end
            S_CLR_DRAIN: begin
                if (!fill_done) state_d = S_SELECT;
                else            state_d = S_CLR_DRAIN;
            end
            S_SELECT: begin
                // Pointer bit 2 set means all four entries have been examined
                if (ptr_q[2]) begin
                    state_d = S_FINISH;
                end else if (entry_valid(entry_q[ptr_q[1:0]])) begin
                    cx_d    = entry_q[ptr_q[1:0]][25:18];
                    cy_d    = entry_q[ptr_q[1:0]][17:11];
                    r_d     = entry_q[ptr_q[1:0]][10:3];
                    col_d   = entry_q[ptr_q[1:0]][2:0];
                    state_d = S_DRAW;
                end else begin
                    ptr_d = ptr_q + 3'd1;
                end
            end
            S_DRAW: begin
                if (circ_done) begin
                    state_d = S_DRW_DRAIN;
                    ptr_d   = ptr_q + 3'd1;
                    cnt_d   = (cnt_q == 3'd4) ? cnt_q : cnt_q + 3'd1;
                end else begin
                    state_d = S_DRAW;
                end
            end
            S_DRW_DRAIN: begin
                if (!circ_done) state_d = S_SELECT;
                else            state_d = S_DRW_DRAIN;
            end
            S_FINISH: begin
                if (!start) state_d = S_IDLE;
                else        state_d = S_FINISH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            cnt_q   <= 3'd0;
            cx_q    <= 8'd0;
            cy_q    <= 7'd0;
            r_q     <= 8'd0;
            col_q   <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                entry_q[i] <= 27'd0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            r_q     <= r_d;
            col_q   <= col_d;
            for (int i = 0; i < 4; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign fill_start   = (state_q == S_CLEAR);
    assign circ_start   = (state_q == S_DRAW);
    assign done         = (state_q == S_FINISH);
    assign circ_cx      = cx_q;
    assign circ_cy      = cy_q;
    assign circ_r       = r_q;
    assign circ_colour  = col_q;
    assign shapes_drawn = cnt_q;

    // Zero-latency VGA mux: only the engine owning the current state reaches the screen
    always_comb begin
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                vga_x      = fill_x;
                vga_y      = fill_y;
                vga_colour = fill_colour;
                vga_plot   = fill_plot;
            end
            S_DRAW: begin
                vga_x      = circ_x;
                vga_y      = circ_y;
                vga_colour = circ_colour_px;
                vga_plot   = circ_plot;
            end
            default: begin
                vga_x      = 8'd0;
                vga_y      = 7'd0;
                vga_colour = 3'd0;
                vga_plot   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shape_scheduler.sv
// Directed bench for shape_scheduler: scene-level shape model plus per-cycle screen-ownership checks.
module tb_shape_scheduler;

    logic        clk = 1'b0;
    logic        rst_n, start, start0, cfg_we;
    logic [1:0]  cfg_addr;
    logic [26:0] cfg_data;
    logic        fill_done, fill_plot, circ_done, circ_plot;
    logic [7:0]  fill_x, circ_x;
    logic [6:0]  fill_y, circ_y;
    logic [2:0]  fill_colour, circ_colour_px;

    logic        done, fill_start, circ_start, vga_plot;
    logic [7:0]  circ_cx, circ_r, vga_x;
    logic [6:0]  circ_cy, vga_y;
    logic [2:0]  circ_colour, vga_colour, shapes_drawn;

    logic        done0, fill_start0, circ_start0, vga_plot0;
    logic [7:0]  circ_cx0, circ_r0, vga_x0;
    logic [6:0]  circ_cy0, vga_y0;
    logic [2:0]  circ_colour0, vga_colour0, shapes_drawn0;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Shape-table model and expected circle order
    bit         m_valid [4];
    logic [7:0] m_cx [4];
    logic [6:0] m_cy [4];
    logic [7:0] m_r [4];
    logic [2:0] m_col [4];
    int         exp_q [$];
    int         obs_cx [8];
    int         n_circ;

    always #5 clk = ~clk;

    shape_scheduler #(.CLEAR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .done(done),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fill_start(fill_start), .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
        .fill_colour(fill_colour), .fill_plot(fill_plot),
        .circ_start(circ_start), .circ_done(circ_done), .circ_cx(circ_cx), .circ_cy(circ_cy),
        .circ_r(circ_r), .circ_colour(circ_colour),
        .circ_x(circ_x), .circ_y(circ_y), .circ_colour_px(circ_colour_px), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .shapes_drawn(shapes_drawn)
    );

    shape_scheduler #(.CLEAR_EN(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .done(done0),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fill_start(fill_start0), .fill_done(fill_done), .fill_x(fill_x), .fill_y(fill_y),
        .fill_colour(fill_colour), .fill_plot(fill_plot),
        .circ_start(circ_start0), .circ_done(circ_done), .circ_cx(circ_cx0), .circ_cy(circ_cy0),
        .circ_r(circ_r0), .circ_colour(circ_colour0),
        .circ_x(circ_x), .circ_y(circ_y), .circ_colour_px(circ_colour_px), .circ_plot(circ_plot),
        .vga_x(vga_x0), .vga_y(vga_y0), .vga_colour(vga_colour0), .vga_plot(vga_plot0),
        .shapes_drawn(shapes_drawn0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] pack(input bit v, input int cx, input int cy, input int r, input int col);
        logic [7:0] a; logic [6:0] b; logic [7:0] c; logic [2:0] d;
        a = cx[7:0]; b = cy[6:0]; c = r[7:0]; d = col[2:0];
        return {v, a, b, c, d};
    endfunction

    task automatic model_write(input logic [1:0] a, input logic [26:0] d);
        m_valid[a] = d[26];
        m_cx[a]    = d[25:18];
        m_cy[a]    = d[17:11];
        m_r[a]     = d[10:3];
        m_col[a]   = d[2:0];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) model_write(i[1:0], 27'd0);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [26:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
        model_write(a, d);
    endtask

    // Screen ownership: only the engine being started may reach the VGA port
    always @(negedge clk) begin
        if (chk_en) begin
            logic [18:0] exp_vga;
            check("starts_exclusive", {31'd0, fill_start & circ_start}, 32'd0);
            if (fill_start)      exp_vga = {fill_plot, fill_x, fill_y, fill_colour};
            else if (circ_start) exp_vga = {circ_plot, circ_x, circ_y, circ_colour_px};
            else                 exp_vga = 19'd0;
            check("vga_mux", {13'd0, vga_plot, vga_x, vga_y, vga_colour}, {13'd0, exp_vga});
        end
    end

    // One full scene on the CLEAR_EN=1 instance, with engine handshakes and pixel traffic
    task automatic do_scene(input bit wr_en, input logic [1:0] wr_addr, input logic [26:0] wr_data,
                            input bit mid_wr, input bit drop_start);
        int k, budget, idx, exp_cnt;
        bit fin;
        start = 1'b1;
        if (wr_en) begin
            cfg_we = 1'b1; cfg_addr = wr_addr; cfg_data = wr_data;
            model_write(wr_addr, wr_data);
        end
        exp_q.delete();
        for (int i = 0; i < 4; i++) if (m_valid[i]) exp_q.push_back(i);
        exp_cnt = (exp_q.size() > 4) ? 4 : exp_q.size();
        tick();
        cfg_we = 1'b0;
        check("clear_start", {31'd0, fill_start}, 32'd1);
        fill_plot = 1'b1; fill_x = 8'd33; fill_y = 7'd21; fill_colour = 3'd5;
        circ_plot = 1'b1; circ_x = 8'd200;
        #1;
        check("clear_vga", {13'd0, vga_plot, vga_x, vga_y, vga_colour}, {13'd0, 1'b1, 8'd33, 7'd21, 3'd5});
        fill_plot = 1'b0;
        #1;
        check("clear_blocks_circ", {31'd0, vga_plot}, 32'd0);
        tick();
        fill_done = 1'b1;
        tick();
        check("clr_drain", {31'd0, fill_start}, 32'd0);
        fill_done = 1'b0; circ_plot = 1'b0;
        tick();
        k = 0; fin = 1'b0; budget = 0;
        while (!fin && budget < 60) begin
            if (circ_start) begin
                if (exp_q.size() == 0) begin
                    check("extra_circle", 32'd1, 32'd0);
                end else begin
                    idx = exp_q.pop_front();
                    check("circ_cx", {24'd0, circ_cx}, {24'd0, m_cx[idx]});
                    check("circ_cy", {25'd0, circ_cy}, {25'd0, m_cy[idx]});
                    check("circ_r", {24'd0, circ_r}, {24'd0, m_r[idx]});
                    check("circ_colour", {29'd0, circ_colour}, {29'd0, m_col[idx]});
                end
                if (k < 8) obs_cx[k] = int'(circ_cx);
                circ_x = 8'd17 + k[7:0]; circ_y = 7'd9; circ_colour_px = 3'd3;
                circ_plot = 1'b1; fill_plot = 1'b1;
                #1;
                check("draw_vga", {13'd0, vga_plot, vga_x, vga_y, vga_colour},
                      {13'd0, 1'b1, 8'd17 + k[7:0], 7'd9, 3'd3});
                if (mid_wr && k == 0) begin
                    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = pack(1'b1, 10, 5, 5, 1);
                end
                tick();
                cfg_we = 1'b0;
                if (drop_start && k == 0) start = 1'b0;
                circ_done = 1'b1;
                tick();
                check("drw_drain", {31'd0, circ_start}, 32'd0);
                check("count_step", {29'd0, shapes_drawn}, (k + 1 > 4) ? 32'd4 : k + 1);
                circ_done = 1'b0; circ_plot = 1'b0; fill_plot = 1'b0;
                k++;
                tick();
            end else if (done) begin
                fin = 1'b1;
                check("final_count", {29'd0, shapes_drawn}, exp_cnt);
                check("all_drawn", exp_q.size(), 32'd0);
            end else begin
                tick();
                budget++;
            end
        end
        if (!fin) check("scene_timeout", 32'd0, 32'd1);
        if (start) begin
            tick();
            check("done_held", {31'd0, done}, 32'd1);
        end
        start = 1'b0;
        tick();
        check("done_release", {31'd0, done}, 32'd0);
        n_circ = k;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 27'd0;
        fill_done = 1'b0; fill_plot = 1'b0; circ_done = 1'b0; circ_plot = 1'b0;
        fill_x = 8'd0; fill_y = 7'd0; fill_colour = 3'd0;
        circ_x = 8'd0; circ_y = 7'd0; circ_colour_px = 3'd0;
        model_reset();
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fill_start", {31'd0, fill_start}, 32'd0);
        check("rst_circ_start", {31'd0, circ_start}, 32'd0);
        check("rst_shapes", {29'd0, shapes_drawn}, 32'd0);
        check("rst_circ_cx", {24'd0, circ_cx}, 32'd0);

        // Empty table, no clear pass: five SELECT cycles then FINISH
        start0 = 1'b1;
        tick();
        n = 0;
        while (!done0 && n < 20) begin
            check("noclr_no_engine", {30'd0, fill_start0, circ_start0}, 32'd0);
            tick();
            n++;
        end
        check("noclr_latency", n, 32'd5);
        check("noclr_shapes", {29'd0, shapes_drawn0}, 32'd0);
        start0 = 1'b0;
        tick();
        check("noclr_done_release", {31'd0, done0}, 32'd0);

        // Empty table with clear pass
        do_scene(1'b0, 2'd0, 27'd0, 1'b0, 1'b0);
        check("empty_circles", n_circ, 32'd0);

        // Write in the same cycle as start is used by this scene
        do_scene(1'b1, 2'd0, pack(1'b1, 80, 60, 40, 2), 1'b0, 1'b0);
        check("one_circles", n_circ, 32'd1);
        check("one_cx_lit", obs_cx[0], 32'd80);
        check("one_shapes_lit", {29'd0, shapes_drawn}, 32'd1);

        // Entries 0 and 2 valid
        cfg_write(2'd2, pack(1'b1, 30, 20, 10, 5));
        do_scene(1'b0, 2'd0, 27'd0, 1'b0, 1'b0);
        check("two_circles", n_circ, 32'd2);
        check("two_order0", obs_cx[0], 32'd80);
        check("two_order1", obs_cx[1], 32'd30);

        // Mid-scene table write ignored; start dropped mid-scene does not abort
        do_scene(1'b0, 2'd0, 27'd0, 1'b1, 1'b1);
        check("drop_circles", n_circ, 32'd2);
        do_scene(1'b0, 2'd0, 27'd0, 1'b0, 1'b0);
        check("old_cx_kept", obs_cx[0], 32'd80);

        // All four entries: count reaches its ceiling
        cfg_write(2'd1, pack(1'b1, 11, 12, 13, 1));
        cfg_write(2'd3, pack(1'b1, 44, 55, 66, 7));
        do_scene(1'b0, 2'd0, 27'd0, 1'b0, 1'b0);
        check("four_circles", n_circ, 32'd4);
        check("four_shapes_lit", {29'd0, shapes_drawn}, 32'd4);

        // Reset while drawing clears state and the shape table
        start = 1'b1;
        tick();
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        start = 1'b0;
        n = 0;
        while (!circ_start && n < 20) begin
            tick();
            n++;
        end
        check("reach_draw", {31'd0, circ_start}, 32'd1);
        circ_plot = 1'b1;
        rst_n = 1'b0;
        tick();
        check("rst_mid_circ_start", {31'd0, circ_start}, 32'd0);
        check("rst_mid_vga_plot", {31'd0, vga_plot}, 32'd0);
        check("rst_mid_fill_start", {31'd0, fill_start}, 32'd0);
        check("rst_mid_circ_cx", {24'd0, circ_cx}, 32'd0);
        check("rst_mid_shapes", {29'd0, shapes_drawn}, 32'd0);
        rst_n = 1'b1;
        circ_plot = 1'b0;
        model_reset();
        do_scene(1'b0, 2'd0, 27'd0, 1'b0, 1'b0);
        check("post_rst_circles", n_circ, 32'd0);
        check("post_rst_shapes", {29'd0, shapes_drawn}, 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
